// File: rtl/program_loader.sv
// Byte-serial boot loader: takes a length-prefixed byte stream and packs
// each group of three bytes into one instruction word. It writes the words
// to instruction memory from address 0 upwards, then releases the CPU.
module program_loader #(
  parameter int WORD_W = 19,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              instr_we,
  output logic [ADDR_W-1:0] instr_waddr,
  output logic [WORD_W-1:0] instr_wdata,
  output logic              cpu_run,
  output logic [7:0]        load_count,
  output logic              err
);

  typedef enum logic [2:0] {
    S_COUNT,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          total_q, total_d;   // word total N from the length byte
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [7:0]          count_q, count_d;
  logic [WORD_W-1:0]   word_q,  word_d;
  logic                err_q,   err_d;
  logic                accept;

  // Only the byte-collecting states take input; WRITE and DONE stall upstream.
  assign in_ready = (state_q == S_COUNT) || (state_q == S_B0) ||
                    (state_q == S_B1)    || (state_q == S_B2);
  assign accept   = in_valid && in_ready;

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    total_d = total_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    err_d   = err_q;

    unique case (state_q)
      S_COUNT: begin
        if (accept) begin
          total_d = in_data;
          state_d = (in_data == 8'd0) ? S_DONE : S_B0;
        end
      end
      S_B0: begin
        if (accept) begin
          // Only a 3-bit opcode is legal; stray upper bits flag an error and
          // are dropped, but the load carries on.
          word_d[WORD_W-1 -: 3] = in_data[2:0];
          if (in_data[7:3] != 5'd0) err_d = 1'b1;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (accept) begin
          word_d[15:8] = in_data;
          state_d      = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          word_d[7:0] = in_data;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 8'd1;
        state_d = ((count_q + 8'd1) == total_q) ? S_DONE : S_B0;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_COUNT;
      end
    endcase
  end

  // State register with synchronous reset overriding any accept or write.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before the edge, independent of statement order.
    if (rst) begin
      // NOTE: the word register is reset too, because its value is visible
      // on instr_wdata straight out of reset; memory itself is never cleared.
      state_q <= S_COUNT;
      total_q <= 8'd0;
      addr_q  <= '0;
      count_q <= 8'd0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign instr_we    = (state_q == S_WRITE);
  assign instr_waddr = addr_q;
  assign instr_wdata = word_q;
  assign cpu_run     = (state_q == S_DONE);
  assign load_count  = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: streams hand-built byte sequences and
// checks write strobes, addresses, data, status outputs and reset behaviour.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        instr_we;
  logic [7:0]  instr_waddr;
  logic [18:0] instr_wdata;
  logic        cpu_run;
  logic [7:0]  load_count;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Write log filled by the monitor below.
  int          nw = 0;
  logic [7:0]  wa [0:1023];
  logic [18:0] wd [0:1023];
  int          wc [0:1023];

  program_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .instr_we    (instr_we),
    .instr_waddr (instr_waddr),
    .instr_wdata (instr_wdata),
    .cpu_run     (cpu_run),
    .load_count  (load_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (instr_we === 1'b1 && nw < 1024) begin
      wa[nw] = instr_waddr;
      wd[nw] = instr_wdata;
      wc[nw] = cyc;
      nw = nw + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one byte and wait (bounded) for the edge that accepts it.
  // Returns #1 after that edge; in_valid stays high unless gap is set.
  task automatic send(input logic [7:0] b, input bit gap);
    bit acc;
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},    32'(in_ready),    32'd1);
    chk({tag, "_instr_we"},    32'(instr_we),    32'd0);
    chk({tag, "_instr_waddr"}, 32'(instr_waddr), 32'd0);
    chk({tag, "_instr_wdata"}, 32'(instr_wdata), 32'd0);
    chk({tag, "_cpu_run"},     32'(cpu_run),     32'd0);
    chk({tag, "_load_count"},  32'(load_count),  32'd0);
    chk({tag, "_err"},         32'(err),         32'd0);
  endtask

  logic [7:0]  stream1 [0:6];
  logic [18:0] exp_w   [0:254];
  logic [7:0]  b0, b1, b2;
  int          base;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    stream1[0] = 8'h02;
    stream1[1] = 8'h07; stream1[2] = 8'h02; stream1[3] = 8'h03;
    stream1[4] = 8'h07; stream1[5] = 8'h01; stream1[6] = 8'h01;

    // Step 1: reset values.
    @(posedge clk); #1;
    chk_reset_vals("reset");
    do_reset();

    // Step 2: two words with in_valid held high.
    base = nw;
    for (int i = 0; i < 7; i++) send(stream1[i], 1'b0);
    // Now #1 after the B2 accept edge: WRITE cycle of word 1.
    chk("t1_we_now",     32'(instr_we),    32'd1);
    chk("t1_waddr_now",  32'(instr_waddr), 32'd1);
    chk("t1_ready_wr",   32'(in_ready),    32'd0);
    chk("t1_run_wr",     32'(cpu_run),     32'd0);
    @(posedge clk); #1;
    chk("t1_cpu_run",    32'(cpu_run),     32'd1);
    chk("t1_load_count", 32'(load_count),  32'd2);
    chk("t1_err",        32'(err),         32'd0);
    chk("t1_we_off",     32'(instr_we),    32'd0);
    chk("t1_nwrites",    32'(nw - base),   32'd2);
    chk("t1_addr0",      32'(wa[base]),    32'd0);
    chk("t1_data0",      32'(wd[base]),    32'(19'b111_00000010_00000011));
    chk("t1_addr1",      32'(wa[base+1]),  32'd1);
    chk("t1_data1",      32'(wd[base+1]),  32'(19'b111_00000001_00000001));
    chk("t1_spacing",    32'(wc[base+1] - wc[base] >= 4), 32'd1);

    // Step 3: same stream with in_valid toggling 1/0.
    do_reset();
    base = nw;
    for (int i = 0; i < 7; i++) send(stream1[i], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_nwrites",    32'(nw - base),   32'd2);
    chk("t2_addr0",      32'(wa[base]),    32'd0);
    chk("t2_data0",      32'(wd[base]),    32'(19'b111_00000010_00000011));
    chk("t2_addr1",      32'(wa[base+1]),  32'd1);
    chk("t2_data1",      32'(wd[base+1]),  32'(19'b111_00000001_00000001));
    chk("t2_spacing",    32'(wc[base+1] - wc[base] >= 6), 32'd1);
    chk("t2_cpu_run",    32'(cpu_run),     32'd1);
    chk("t2_load_count", 32'(load_count),  32'd2);

    // Step 4: malformed opcode byte.
    do_reset();
    base = nw;
    send(8'h01, 1'b0);
    chk("t3_err_before", 32'(err), 32'd0);
    send(8'hF9, 1'b0);
    chk("t3_err_at_b0",  32'(err), 32'd1);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    chk("t3_we",         32'(instr_we),    32'd1);
    chk("t3_wdata",      32'(instr_wdata), 32'(19'b001_00000000_00000010));
    @(posedge clk); #1;
    chk("t3_cpu_run",    32'(cpu_run),     32'd1);
    chk("t3_err_sticky", 32'(err),         32'd1);
    chk("t3_nwrites",    32'(nw - base),   32'd1);

    // Step 5: empty program.
    do_reset();
    base = nw;
    send(8'h00, 1'b0);
    chk("t4_cpu_run",    32'(cpu_run),  32'd1);
    chk("t4_ready",      32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_ready_held", 32'(in_ready),   32'd0);
    chk("t4_run_held",   32'(cpu_run),    32'd1);
    chk("t4_load_count", 32'(load_count), 32'd0);
    chk("t4_nwrites",    32'(nw - base),  32'd0);
    in_valid = 1'b0;

    // Step 6: reset during B1 of the second word of an N=3 load.
    do_reset();
    base = nw;
    send(8'h03, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);        // B0 of word 1 (waits out the WRITE cycle)
    chk("t5_pre_count", 32'(load_count), 32'd1);
    in_data = 8'h99;          // B1 byte offered together with reset
    rst     = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("t5_rst");
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("t5_nwrites_pre", 32'(nw - base), 32'd1);
    base = nw;
    send(8'h01, 1'b0);
    send(8'h05, 1'b0);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    @(posedge clk); #1;
    chk("t5_nwrites", 32'(nw - base), 32'd1);
    chk("t5_addr",    32'(wa[base]),  32'd0);
    chk("t5_data",    32'(wd[base]),  32'(19'b101_00000000_00000010));
    chk("t5_cpu_run", 32'(cpu_run),   32'd1);

    // Step 7: full-size N=255 load with random words.
    do_reset();
    base = nw;
    send(8'hFF, 1'b0);
    for (int k = 0; k < 255; k++) begin
      b0 = 8'($urandom_range(0, 7));
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      exp_w[k] = {b0[2:0], b1, b2};
      send(b0, 1'b0);
      send(b1, 1'b0);
      send(b2, 1'b0);
    end
    @(posedge clk); #1;
    chk("t6_nwrites",    32'(nw - base),  32'd255);
    for (int k = 0; k < 255; k++) begin
      chk($sformatf("t6_addr%0d", k), 32'(wa[base+k]), 32'(k));
      chk($sformatf("t6_data%0d", k), 32'(wd[base+k]), 32'(exp_w[k]));
    end
    chk("t6_load_count", 32'(load_count), 32'd255);
    chk("t6_cpu_run",    32'(cpu_run),    32'd1);
    chk("t6_err",        32'(err),        32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_run_cleared", 32'(cpu_run),    32'd0);
    chk("t6_count_clr",   32'(load_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
